video_frame_arbiter: RTL and testbench

- Shares one video down-sample datapath between two AXI4-Stream video sources.
- Sits upstream of the down-sampler's slave interface and grants the stream one whole frame at a time, alternating between the sources round-robin.
- Discards beats that arrive before a start-of-frame, and truncates frames that end early so the down-sampler always sees aligned frames.

---
 rtl/video_frame_arbiter.sv | 132 +++++++++++++
 tb/tb_video_frame_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_frame_arbiter.sv
// Frame-granular round-robin arbiter that feeds two AXI4-Stream video sources
// into one down-sampler. It drops beats that arrive before a start-of-frame and
// truncates frames that end early.
module video_frame_arbiter #(
  parameter int DATA_WIDTH     = 24,
  parameter int LINE_CNT_WIDTH = 12,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [1:0]                cfg_en,
  input  logic [LINE_CNT_WIDTH-1:0] cfg_lines,
  input  logic                      s0_axis_tvalid,
  output logic                      s0_axis_tready,
  input  logic [DATA_WIDTH-1:0]     s0_axis_tdata,
  input  logic                      s0_axis_tlast,
  input  logic                      s0_axis_tuser,
  input  logic                      s1_axis_tvalid,
  output logic                      s1_axis_tready,
  input  logic [DATA_WIDTH-1:0]     s1_axis_tdata,
  input  logic                      s1_axis_tlast,
  input  logic                      s1_axis_tuser,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tuser,
  output logic [1:0]                grant,
  output logic [CNT_WIDTH-1:0]      frame_cnt0,
  output logic [CNT_WIDTH-1:0]      frame_cnt1,
  output logic [CNT_WIDTH-1:0]      drop_cnt0,
  output logic [CNT_WIDTH-1:0]      drop_cnt1,
  output logic                      err_short
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                    state, state_nxt;
  logic                      rr_pri;
  logic [LINE_CNT_WIDTH-1:0] lines_lat, line_cnt;
  logic                      first_beat;

  logic [1:0]            elig, drop;
  logic                  pick, gidx, in_grant;
  logic                  sel_vld, sel_last, sel_user;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  early_sof, pass_rdy, hs, frame_done, frame_end;

  always_comb begin
    elig      = cfg_en & {s1_axis_tvalid & s1_axis_tuser, s0_axis_tvalid & s0_axis_tuser};
    drop      = 2'b00;
    in_grant  = (state == GRANT);
    gidx      = grant[1];
    sel_vld   = gidx ? s1_axis_tvalid : s0_axis_tvalid;
    sel_data  = gidx ? s1_axis_tdata  : s0_axis_tdata;
    sel_last  = gidx ? s1_axis_tlast  : s0_axis_tlast;
    sel_user  = gidx ? s1_axis_tuser  : s0_axis_tuser;
    pick      = (elig == 2'b11) ? rr_pri : elig[1];
    if (state == IDLE && !areset)
      drop = cfg_en & {s1_axis_tvalid & ~s1_axis_tuser, s0_axis_tvalid & ~s0_axis_tuser};

    // Any SOF after the first beat means the current frame ended early; hold it back.
    early_sof = in_grant && sel_vld && sel_user && (line_cnt != '0 || !first_beat);

    m_axis_tvalid  = in_grant && sel_vld && !early_sof && !areset;
    m_axis_tdata   = in_grant ? sel_data : '0;
    m_axis_tlast   = in_grant && sel_last;
    m_axis_tuser   = in_grant && sel_user;
    pass_rdy       = in_grant && m_axis_tready && !early_sof && !areset;
    s0_axis_tready = drop[0] | (pass_rdy & grant[0]);
    s1_axis_tready = drop[1] | (pass_rdy & grant[1]);

    hs         = m_axis_tvalid && m_axis_tready;
    frame_done = hs && sel_last && (line_cnt == lines_lat - LINE_CNT_WIDTH'(1));
    frame_end  = frame_done || early_sof;

    state_nxt = state;
    case (state)
      IDLE:    if (elig != 2'b00) state_nxt = GRANT;
      GRANT:   if (frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      grant      <= 2'b00;
      rr_pri     <= 1'b0;
      lines_lat  <= '0;
      line_cnt   <= '0;
      first_beat <= 1'b0;
      frame_cnt0 <= '0;
      frame_cnt1 <= '0;
      drop_cnt0  <= '0;
      drop_cnt1  <= '0;
      err_short  <= 1'b0;
    end else begin
      if (drop[0]) drop_cnt0 <= drop_cnt0 + 1'b1;
      if (drop[1]) drop_cnt1 <= drop_cnt1 + 1'b1;
      case (state)
        IDLE: begin
          if (elig != 2'b00) begin
            grant      <= pick ? 2'b10 : 2'b01;
            lines_lat  <= (cfg_lines == '0) ? LINE_CNT_WIDTH'(1) : cfg_lines;
            line_cnt   <= '0;
            first_beat <= 1'b1;
          end
        end
        GRANT: begin
          if (hs) begin
            first_beat <= 1'b0;
            if (sel_last) line_cnt <= line_cnt + 1'b1;
          end
          if (frame_end) begin
            grant  <= 2'b00;
            rr_pri <= ~gidx;
            if (gidx) frame_cnt1 <= frame_cnt1 + 1'b1;
            else      frame_cnt0 <= frame_cnt0 + 1'b1;
          end
          if (early_sof) err_short <= 1'b1;
        end
        default: grant <= 2'b00;
      endcase
    end
  end

endmodule

// File: tb/tb_video_frame_arbiter.sv
// Bench for video_frame_arbiter: random frame streams per source, checked beat by
// beat against a per-source frame model, plus directed round-robin and reset cases.
module tb_video_frame_arbiter;
  localparam int DW = 24;
  localparam int LW = 12;
  localparam int CW = 16;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [1:0]    cfg_en = 2'b00;
  logic [LW-1:0] cfg_lines = '0;
  logic          s0_axis_tvalid = 1'b0, s0_axis_tready, s0_axis_tlast = 1'b0, s0_axis_tuser = 1'b0;
  logic          s1_axis_tvalid = 1'b0, s1_axis_tready, s1_axis_tlast = 1'b0, s1_axis_tuser = 1'b0;
  logic [DW-1:0] s0_axis_tdata = '0, s1_axis_tdata = '0;
  logic          m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tlast, m_axis_tuser;
  logic [DW-1:0] m_axis_tdata;
  logic [1:0]    grant;
  logic [CW-1:0] frame_cnt0, frame_cnt1, drop_cnt0, drop_cnt1;
  logic          err_short;

  video_frame_arbiter #(.DATA_WIDTH(DW), .LINE_CNT_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .aclk(aclk), .areset(areset), .cfg_en(cfg_en), .cfg_lines(cfg_lines),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready), .s0_axis_tdata(s0_axis_tdata),
    .s0_axis_tlast(s0_axis_tlast), .s0_axis_tuser(s0_axis_tuser),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready), .s1_axis_tdata(s1_axis_tdata),
    .s1_axis_tlast(s1_axis_tlast), .s1_axis_tuser(s1_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .grant(grant),
    .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1), .drop_cnt0(drop_cnt0), .drop_cnt1(drop_cnt1),
    .err_short(err_short)
  );

  always #5 aclk = ~aclk;

  // Beat packing: {tuser, tlast, tdata}
  logic [DW+1:0] mq0[$], mq1[$], stim0[$], stim1[$], exp0[$], exp1[$];
  int   gorder[$];
  int   nout = 0, nchk = 0, nerr = 0;
  bit   bp_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic push(input int src, input logic [DW+1:0] b);
    if (src == 0) mq0.push_back(b);
    else          mq1.push_back(b);
  endtask

  task automatic gen_frame(input int src, input int nlines, input int bpl, input int garbage);
    for (int g = 0; g < garbage; g++)
      push(src, {1'b0, 1'($urandom % 2), DW'($urandom)});
    for (int l = 0; l < nlines; l++)
      for (int b = 0; b < bpl; b++)
        push(src, {(l == 0 && b == 0), (b == bpl - 1), DW'($urandom)});
  endtask

  task automatic gen_rand(input int src, input int lines);
    int nf, le, nl, g;
    bit short_f, prev_short;
    nf = 2 + $urandom % 2;
    le = (lines == 0) ? 1 : lines;
    prev_short = 1'b0;
    for (int f = 0; f < nf; f++) begin
      g       = prev_short ? 0 : $urandom % 3;
      short_f = (f < nf - 1) && (le > 1) && ($urandom % 3 == 0);
      nl      = short_f ? 1 + $urandom % (le - 1) : le;
      gen_frame(src, nl, 1 + $urandom % 4, g);
      prev_short = short_f;
    end
  endtask

  // Frame-level view of one source: drop until SOF, pass a frame of L lines,
  // cut it short when another SOF shows up after its first beat.
  task automatic model(input int src, input int lines, output int frames, output int drops, output bit err);
    logic [DW+1:0] b[$], e[$];
    int i, lc, L;
    bit in_f, first;
    b = (src == 0) ? mq0 : mq1;
    L = (lines == 0) ? 1 : lines;
    frames = 0; drops = 0; err = 1'b0; i = 0; in_f = 1'b0; first = 1'b0; lc = 0;
    while (i < b.size()) begin
      if (!in_f) begin
        if (b[i][DW+1]) begin in_f = 1'b1; first = 1'b1; lc = 0; end
        else begin drops++; i++; end
      end else if (b[i][DW+1] && !first) begin
        err = 1'b1; frames++; in_f = 1'b0;
      end else begin
        e.push_back(b[i]); first = 1'b0;
        if (b[i][DW]) begin
          lc++;
          if (lc == L) begin frames++; in_f = 1'b0; end
        end
        i++;
      end
    end
    if (src == 0) exp0 = e;
    else          exp1 = e;
  endtask

  // Source drivers and output monitor share one loop: sample at negedge, drive after posedge.
  initial begin : drive_mon
    logic          hs0, hs1;
    logic [1:0]    pg;
    logic [DW+1:0] beat;
    logic [31:0]   want;
    pg = 2'b00;
    forever begin
      @(negedge aclk);
      hs0 = s0_axis_tvalid && s0_axis_tready;
      hs1 = s1_axis_tvalid && s1_axis_tready;
      if (grant == 2'b00)      chk("idle_vld", 32'(m_axis_tvalid), 32'd0);
      else if (grant == 2'b01) chk("s1_rdy_blocked", 32'(s1_axis_tready), 32'd0);
      else if (grant == 2'b10) chk("s0_rdy_blocked", 32'(s0_axis_tready), 32'd0);
      else                     chk("grant_onehot", 32'(grant), 32'd1);
      if (pg == 2'b00 && grant != 2'b00) gorder.push_back(grant[1] ? 1 : 0);
      pg = grant;
      if (m_axis_tvalid && m_axis_tready) begin
        nout++;
        beat = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
        want = 32'hFFFF_FFFF;
        if (grant[1]) begin
          if (exp1.size() > 0) want = 32'(exp1.pop_front());
          chk("beat_s1", 32'(beat), want);
        end else begin
          if (exp0.size() > 0) want = 32'(exp0.pop_front());
          chk("beat_s0", 32'(beat), want);
        end
      end
      @(posedge aclk);
      #1;
      if (hs0 && stim0.size() > 0) void'(stim0.pop_front());
      if (hs1 && stim1.size() > 0) void'(stim1.pop_front());
      s0_axis_tvalid = (stim0.size() > 0);
      if (stim0.size() > 0) {s0_axis_tuser, s0_axis_tlast, s0_axis_tdata} = stim0[0];
      s1_axis_tvalid = (stim1.size() > 0);
      if (stim1.size() > 0) {s1_axis_tuser, s1_axis_tlast, s1_axis_tdata} = stim1[0];
      m_axis_tready = bp_on ? 1'($urandom % 2) : 1'b1;
    end
  end

  task automatic clear_all();
    mq0.delete(); mq1.delete(); stim0.delete(); stim1.delete();
    exp0.delete(); exp1.delete(); gorder.delete();
  endtask

  task automatic do_reset();
    @(posedge aclk); #2;
    areset = 1'b1;
    clear_all();
    repeat (2) @(posedge aclk);
    #2 areset = 1'b0;
  endtask

  task automatic run(input string name, input int lines, input logic [1:0] en, input bit bp);
    int f0, f1, d0, d1, ntot;
    bit e0, e1, done;
    @(negedge aclk);
    cfg_lines = LW'(lines); cfg_en = en; bp_on = bp;
    model(0, lines, f0, d0, e0);
    model(1, lines, f1, d1, e1);
    ntot = exp0.size() + exp1.size();
    nout = 0; gorder.delete();
    stim0 = mq0; stim1 = mq1;
    done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge aclk);
      done = stim0.size() == 0 && stim1.size() == 0 && grant == 2'b00 &&
             exp0.size() == 0 && exp1.size() == 0;
    end
    chk({name, "_drained"}, 32'(done), 32'd1);
    repeat (2) @(negedge aclk);
    chk({name, "_beats"}, nout, ntot);
    chk({name, "_grant_end"}, 32'(grant), 32'd0);
    chk({name, "_frame_cnt0"}, 32'(frame_cnt0), f0);
    chk({name, "_frame_cnt1"}, 32'(frame_cnt1), f1);
    chk({name, "_drop_cnt0"}, 32'(drop_cnt0), d0);
    chk({name, "_drop_cnt1"}, 32'(drop_cnt1), d1);
    chk({name, "_err_short"}, 32'(err_short), 32'(e0 | e1));
    mq0.delete(); mq1.delete();
  endtask

  initial begin : main
    bit seen;
    // Reset: a garbage beat presented on an enabled source must not be taken.
    cfg_en = 2'b11;
    stim0.push_back({1'b0, 1'b0, DW'(24'h123456)});
    repeat (3) @(negedge aclk);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_s0_rdy", 32'(s0_axis_tready), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_cnts", 32'({frame_cnt0, drop_cnt1}), 32'd0);
    chk("rst_err", 32'(err_short), 32'd0);
    stim0.delete();
    #2 areset = 1'b0;

    // Single source, one 4-line x 8-beat frame.
    do_reset();
    gen_frame(0, 4, 8, 0);
    run("single", 4, 2'b01, 1'b0);
    chk("single_beats32", nout, 32);

    // Round robin with both sources holding SOF.
    do_reset();
    gen_frame(0, 2, 3, 0); gen_frame(0, 2, 2, 0);
    gen_frame(1, 2, 2, 0); gen_frame(1, 2, 3, 0);
    run("rr", 2, 2'b11, 1'b0);
    for (int k = 0; k < 4; k++)
      chk("rr_order", (gorder.size() > k) ? gorder[k] : 9, k % 2);

    // Pre-SOF garbage on source 1.
    do_reset();
    gen_frame(1, 3, 4, 5);
    run("garbage", 3, 2'b10, 1'b0);
    chk("garbage_drop5", 32'(drop_cnt1), 32'd5);

    // Short frame followed by a full one.
    do_reset();
    gen_frame(0, 2, 3, 0); gen_frame(0, 4, 3, 0);
    run("short", 4, 2'b01, 1'b0);
    chk("short_err", 32'(err_short), 32'd1);

    // Random traffic with downstream backpressure; one pass with cfg_lines=0.
    for (int it = 0; it < 6; it++) begin
      int L;
      L = (it == 5) ? 0 : 1 + $urandom % 4;
      do_reset();
      gen_rand(0, L);
      gen_rand(1, L);
      run("rand", L, 2'b11, 1'b1);
    end

    // Reset mid-frame at beat 10.
    do_reset();
    @(negedge aclk);
    cfg_en = 2'b01; cfg_lines = 4; bp_on = 1'b0; nout = 0;
    gen_frame(0, 4, 8, 0);
    begin
      int f0, d0;
      bit e0;
      model(0, 4, f0, d0, e0);
    end
    stim0 = mq0;
    seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(posedge aclk);
      seen = (nout >= 10);
    end
    chk("midrst_reached", 32'(seen), 32'd1);
    #2 areset = 1'b1;
    #1;
    chk("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("midrst_s0_rdy", 32'(s0_axis_tready), 32'd0);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_tdata", 32'(m_axis_tdata), 32'd0);
    clear_all();
    repeat (2) @(posedge aclk);
    #2 areset = 1'b0;
    gen_frame(0, 2, 2, 0);
    gen_frame(1, 2, 2, 0);
    run("postrst", 2, 2'b11, 1'b0);
    chk("postrst_first_src0", (gorder.size() > 0) ? gorder[0] : 9, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
